// File: rtl/grey_arb_pkg.sv
// grey_arb_pkg: shared types and helpers for the grey-to-binary conversion arbiter.
//   state_t  : output-register occupancy (EMPTY / FULL)
//   clog2    : ceiling log2, used to validate the requester ID width
//   rr_pick  : round-robin one-hot pick over up to 16 requesters
package grey_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((64'd1 << r) < 64'(v)) r = r + 1;
      end
      return r;
   endfunction

   // Search upward from ptr, wrapping modulo n; return the first set bit of
   // valid as a one-hot vector (all zero when nothing is valid).
   function automatic logic [15:0] rr_pick(input logic [15:0] valid,
                                           input int unsigned ptr,
                                           input int unsigned n);
      logic [15:0] gnt;
      logic        found;
      int unsigned idx;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 16; k++) begin
         if (k < n) begin
            idx = (ptr + k) % n;
            if (!found && valid[idx[3:0]]) begin
               gnt[idx[3:0]] = 1'b1;
               found         = 1'b1;
            end
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/grey2bin_core.sv
// grey2bin_core: combinational grey-to-binary converter.
//   g : grey-coded input word  (SZ bits)
//   b : binary output word     (SZ bits), b[k] = XOR of g[SZ-1:k]
module grey2bin_core #(
   parameter int unsigned SZ = 6
) (
   input  logic [SZ-1:0] g,
   output logic [SZ-1:0] b
);

   logic acc;

   // Running XOR from the MSB downward.
   always_comb begin
      acc = 1'b0;
      b   = '0;
      for (int unsigned k = 0; k < SZ; k++) begin
         acc           = acc ^ g[SZ-1-k];
         b[SZ-1-k]     = acc;
      end
   end

endmodule

// File: rtl/grey_conv_arbiter.sv
// grey_conv_arbiter: one shared grey-to-binary converter serving NREQ
// requesters under round-robin arbitration, with a single registered output.
//   clk, reset : clock and synchronous active-high reset
//   req_valid  : per-requester word present
//   req_g      : per-requester grey words, requester i at [i*SZ +: SZ]
//   req_ready  : one-hot (or zero) acceptance, combinational
//   out_valid  : output register holds a result
//   out_b      : binary result
//   out_id     : requester that produced out_b
//   out_ready  : downstream takes the result this cycle
//   busy_cnt   : saturating count of cycles with a waiting, ungranted request
module grey_conv_arbiter
   import grey_arb_pkg::*;
#(
   parameter int unsigned SZ   = 6,
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*SZ-1:0] req_g,
   output logic [NREQ-1:0]    req_ready,
   output logic               out_valid,
   output logic [SZ-1:0]      out_b,
   output logic [IDW-1:0]     out_id,
   input  logic               out_ready,
   output logic [15:0]        busy_cnt
);

   generate
      if (IDW != clog2(NREQ)) begin : g_bad_idw
         $error("grey_conv_arbiter: IDW must equal clog2(NREQ)");
      end
   endgenerate

   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   state_t          state, state_nx;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  gnt_id;
   logic [15:0]     valid_ext;
   logic [15:0]     pick;
   logic [NREQ-1:0] grant;
   logic [SZ-1:0]   g_sel;
   logic [SZ-1:0]   b_sel;
   logic            accept;
   logic            any_gnt;
   logic            waiting;

   // Arbitration: grant only when the output register can take a new result.
   always_comb begin
      valid_ext              = '0;
      valid_ext[NREQ-1:0]    = req_valid;
      accept                 = (state == EMPTY) || out_ready;
      pick                   = rr_pick(valid_ext, 32'(rr_ptr), NREQ);
      grant                  = (accept && !reset) ? pick[NREQ-1:0] : '0;
      any_gnt                = |grant;
      waiting                = |(req_valid & ~grant);
   end

   assign req_ready = grant;

   // AND-OR mux on the one-hot grant: non-granted words are masked by a known
   // zero select, so unknowns on idle requesters never reach the converter.
   always_comb begin
      g_sel  = '0;
      gnt_id = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            g_sel  = g_sel | req_g[i*SZ +: SZ];
            gnt_id = IDW'(i);
         end
      end
   end

   grey2bin_core #(.SZ(SZ)) u_conv (
      .g (g_sel),
      .b (b_sel)
   );

   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   if (any_gnt) state_nx = FULL;
         FULL:    if (out_ready) state_nx = any_gnt ? FULL : EMPTY;
         default: state_nx = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= EMPTY;
         out_b    <= '0;
         out_id   <= '0;
         rr_ptr   <= '0;
         busy_cnt <= '0;
      end else begin
         state <= state_nx;
         if (any_gnt) begin
            out_b  <= b_sel;
            out_id <= gnt_id;
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
         end
         if (waiting && (busy_cnt != '1)) busy_cnt <= busy_cnt + 16'd1;
      end
   end

   assign out_valid = (state == FULL);

endmodule
